// File: rtl/clk_en_pkg.sv
// Shared state encoding and default rate constants for the clock-enable generator.
package clk_en_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    PAUSED = 2'd2,
    STEP   = 2'd3
  } clken_state_t;

  localparam int DEF_ACC_NUM      = 3;
  localparam int DEF_ACC_DEN      = 14;
  localparam int DEF_PPU_PER_CPU  = 12;
  localparam int DEF_PPU_PER_DIV4 = 4;
  localparam int DEF_VGA_DIV      = 8;

endpackage

// File: rtl/clk_enable_gen_frac.sv
// frac_strobe: fractional accumulator producing NUM strobes per DEN clocks.
// While hold is high the accumulator is frozen and the strobe is forced low.
module frac_strobe #(
  parameter int NUM = 3,
  parameter int DEN = 14
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic fire,
  output logic strobe
);

  // One spare bit so acc + NUM can never wrap before the compare.
  localparam int AW = $clog2(DEN) + 1;

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic          carry;

  assign sum   = acc + AW'(NUM);
  assign carry = (sum >= AW'(DEN));
  assign fire  = !hold && carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= fire;
      if (!hold) begin
        acc <= carry ? (sum - AW'(DEN)) : sum;
      end
    end
  end

endmodule

// File: rtl/clk_enable_gen.sv
// Clock-enable generator: PPU, PPU/4, CPU and VGA strobes with a pause handshake.
// Define CLKEN_STEP_EN to add the step port and single-CPU-cycle STEP state.
module clk_enable_gen
  import clk_en_pkg::*;
#(
  parameter int ACC_NUM      = DEF_ACC_NUM,
  parameter int ACC_DEN      = DEF_ACC_DEN,
  parameter int PPU_PER_CPU  = DEF_PPU_PER_CPU,
  parameter int PPU_PER_DIV4 = DEF_PPU_PER_DIV4,
  parameter int VGA_DIV      = DEF_VGA_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause_req,
  output logic pause_ack,
`ifdef CLKEN_STEP_EN
  input  logic step,
`endif
  output logic ce_ppu,
  output logic ce_ppu4,
  output logic ce_cpu,
  output logic ce_vga
);

  localparam int CW = $clog2(PPU_PER_CPU > 1 ? PPU_PER_CPU : 2);
  localparam int DW = $clog2(PPU_PER_DIV4 > 1 ? PPU_PER_DIV4 : 2);
  localparam int VW = $clog2(VGA_DIV > 1 ? VGA_DIV : 2);

  clken_state_t  state;
  logic [CW-1:0] ppu_cnt;
  logic [DW-1:0] div4_cnt;
  logic [VW-1:0] vga_cnt;
  logic          hold;
  logic          ppu_fire;
  logic          cpu_fire;
  logic          div4_fire;
  logic          vga_wrap;

  assign hold      = (state == PAUSED);
  assign cpu_fire  = ppu_fire && (ppu_cnt == CW'(PPU_PER_CPU - 1));
  assign div4_fire = ppu_fire && (div4_cnt == DW'(PPU_PER_DIV4 - 1));
  assign vga_wrap  = (vga_cnt == VW'(VGA_DIV - 1));

  frac_strobe #(
    .NUM (ACC_NUM),
    .DEN (ACC_DEN)
  ) u_ppu_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (hold),
    .fire   (ppu_fire),
    .strobe (ce_ppu)
  );

  // ppu_fire is already gated by hold, so the divided strobes freeze with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppu_cnt  <= '0;
      div4_cnt <= '0;
      vga_cnt  <= '0;
      ce_cpu   <= 1'b0;
      ce_ppu4  <= 1'b0;
      ce_vga   <= 1'b0;
    end else begin
      if (ppu_fire) begin
        ppu_cnt  <= cpu_fire  ? '0 : ppu_cnt + 1'b1;
        div4_cnt <= div4_fire ? '0 : div4_cnt + 1'b1;
      end
      ce_cpu  <= cpu_fire;
      ce_ppu4 <= div4_fire;
      vga_cnt <= vga_wrap ? '0 : vga_cnt + 1'b1;
      ce_vga  <= vga_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pause_ack <= 1'b0;
    end else begin
      pause_ack <= (state == PAUSED);
      case (state)
        RUN: begin
          if (pause_req) state <= cpu_fire ? PAUSED : DRAIN;
        end
        DRAIN: begin
          if (!pause_req)   state <= RUN;
          else if (cpu_fire) state <= PAUSED;
        end
        PAUSED: begin
          if (!pause_req) state <= RUN;
`ifdef CLKEN_STEP_EN
          else if (step)  state <= STEP;
`endif
        end
        STEP: begin
          if (cpu_fire) state <= PAUSED;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: directed pause scenarios plus random pause traffic
// against an arithmetic reference model (ppu strobes from floor(n*NUM/DEN) over active edges).
module tb_clk_enable_gen;

  localparam int ACC_NUM      = 3;
  localparam int ACC_DEN      = 14;
  localparam int PPU_PER_CPU  = 12;
  localparam int PPU_PER_DIV4 = 4;
  localparam int VGA_DIV      = 8;

  localparam int M_RUN    = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_PAUSED = 2;
  localparam int M_STEP   = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic pause_req;
  logic pause_ack;
`ifdef CLKEN_STEP_EN
  logic step;
`endif
  logic ce_ppu, ce_ppu4, ce_cpu, ce_vga;

  int n_compared = 0;
  int n_failed   = 0;

  int edge_no;
  int m_act, m_nppu, m_mode;
  int cnt_ppu, cnt_ppu4, cnt_cpu, cnt_vga;
  int first_ppu4_edge, first_cpu_edge, first_vga_edge;
  int last_ppu_edge, last_cpu_edge;
  bit ack_seen;

  clk_enable_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pause_req (pause_req),
    .pause_ack (pause_ack),
`ifdef CLKEN_STEP_EN
    .step      (step),
`endif
    .ce_ppu    (ce_ppu),
    .ce_ppu4   (ce_ppu4),
    .ce_cpu    (ce_cpu),
    .ce_vga    (ce_vga)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d (edge %0d)", tag, observed, expected, edge_no);
    end
  endtask

  task automatic clear_counts();
    cnt_ppu = 0; cnt_ppu4 = 0; cnt_cpu = 0; cnt_vga = 0;
    first_ppu4_edge = 0; first_cpu_edge = 0; first_vga_edge = 0;
    last_ppu_edge = 0; last_cpu_edge = 0;
    ack_seen = 1'b0;
  endtask

  // Asserted between edges, so it also exercises asynchronous reset mid-operation.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_output("reset_ce_ppu", ce_ppu, 0);
    check_output("reset_ce_ppu4", ce_ppu4, 0);
    check_output("reset_ce_cpu", ce_cpu, 0);
    check_output("reset_ce_vga", ce_vga, 0);
    check_output("reset_pause_ack", pause_ack, 0);
    pause_req = 1'b0;
`ifdef CLKEN_STEP_EN
    step = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edge_no = 0; m_act = 0; m_nppu = 0; m_mode = M_RUN;
    clear_counts();
  endtask

  // One rising edge: advance the reference model, then compare one time unit later.
  task automatic tick();
    bit frz, req, stp, e_ppu, e_ppu4, e_cpu, e_vga, e_ack;
    @(posedge clk);
    edge_no++;
    req = pause_req;
    stp = 1'b0;
`ifdef CLKEN_STEP_EN
    stp = step;
`endif
    frz = (m_mode == M_PAUSED);
    e_ppu = 0; e_ppu4 = 0; e_cpu = 0;
    if (!frz) begin
      m_act++;
      if ((m_act * ACC_NUM) / ACC_DEN != ((m_act - 1) * ACC_NUM) / ACC_DEN) begin
        e_ppu = 1;
        m_nppu++;
        e_ppu4 = (m_nppu % PPU_PER_DIV4) == 0;
        e_cpu  = (m_nppu % PPU_PER_CPU) == 0;
      end
    end
    e_vga = (edge_no % VGA_DIV) == 0;
    e_ack = frz;
    case (m_mode)
      M_RUN:    if (req) m_mode = e_cpu ? M_PAUSED : M_DRAIN;
      M_DRAIN:  if (!req) m_mode = M_RUN; else if (e_cpu) m_mode = M_PAUSED;
      M_PAUSED: if (!req) m_mode = M_RUN; else if (stp) m_mode = M_STEP;
      default:  if (e_cpu) m_mode = M_PAUSED;
    endcase
    #1;
    check_output("ce_ppu", ce_ppu, e_ppu);
    check_output("ce_ppu4", ce_ppu4, e_ppu4);
    check_output("ce_cpu", ce_cpu, e_cpu);
    check_output("ce_vga", ce_vga, e_vga);
    check_output("pause_ack", pause_ack, e_ack);
    if (ce_ppu === 1'b1) begin cnt_ppu++; last_ppu_edge = edge_no; end
    if (ce_ppu4 === 1'b1) begin cnt_ppu4++; if (first_ppu4_edge == 0) first_ppu4_edge = edge_no; end
    if (ce_cpu === 1'b1) begin
      cnt_cpu++; last_cpu_edge = edge_no;
      if (first_cpu_edge == 0) first_cpu_edge = edge_no;
    end
    if (ce_vga === 1'b1) begin cnt_vga++; if (first_vga_edge == 0) first_vga_edge = edge_no; end
    if (pause_ack === 1'b1) ack_seen = 1'b1;
  endtask

  task automatic run_to(input int target);
    while (edge_no < target) tick();
  endtask

  initial begin
    int dur;
    rst_n = 1'b1;
    pause_req = 1'b0;
`ifdef CLKEN_STEP_EN
    step = 1'b0;
`endif
    #2;

    $display("[TB] free-running schedule");
    do_reset();
    run_to(112);
    check_output("run112_ppu_count", cnt_ppu, 24);
    check_output("run112_ppu4_count", cnt_ppu4, 6);
    check_output("run112_cpu_count", cnt_cpu, 2);
    check_output("run112_vga_count", cnt_vga, 14);
    check_output("first_ppu4_edge", first_ppu4_edge, 19);
    check_output("first_cpu_edge", first_cpu_edge, 56);
    check_output("first_vga_edge", first_vga_edge, 8);
    check_output("second_cpu_edge", last_cpu_edge, 112);

    $display("[TB] pause from edge 20, release at edge 200");
    do_reset();
    run_to(19);
    pause_req = 1'b1;
    run_to(56);
    check_output("drain_boundary_cpu", last_cpu_edge, 56);
    run_to(57);
    check_output("ack_after_drain", pause_ack, 1);
    clear_counts();
    run_to(199);
    pause_req = 1'b0;
    run_to(200);
    check_output("paused_ppu_count", cnt_ppu, 0);
    check_output("paused_vga_count", cnt_vga, 18);
    run_to(201);
    check_output("ack_after_release", pause_ack, 0);
    clear_counts();
    run_to(256);
    check_output("resume_first_ppu", cnt_ppu > 0 ? 205 : 0, 205);
    check_output("resume_cpu_edge", last_cpu_edge, 256);
    check_output("resume_cpu_count", cnt_cpu, 1);

    $display("[TB] pause on the boundary edge");
    do_reset();
    run_to(55);
    pause_req = 1'b1;
    run_to(56);
    check_output("direct_boundary_cpu", last_cpu_edge, 56);
    run_to(57);
    check_output("direct_ack", pause_ack, 1);
    run_to(80);
    pause_req = 1'b0;
    run_to(90);

    $display("[TB] short pause request inside DRAIN");
    do_reset();
    run_to(19);
    pause_req = 1'b1;
    run_to(29);
    pause_req = 1'b0;
    run_to(112);
    check_output("aborted_ack_seen", ack_seen, 0);
    check_output("aborted_cpu_count", cnt_cpu, 2);
    check_output("aborted_ppu_count", cnt_ppu, 24);

    $display("[TB] async reset while paused");
    do_reset();
    pause_req = 1'b1;
    run_to(120);
    check_output("paused_before_reset", pause_ack, 1);
    #2;
    do_reset();
    run_to(60);
    check_output("post_reset_cpu_edge", first_cpu_edge, 56);
    check_output("post_reset_ack_seen", ack_seen, 0);

`ifdef CLKEN_STEP_EN
    $display("[TB] single step while paused");
    do_reset();
    pause_req = 1'b1;
    run_to(70);
    step = 1'b1;
    tick();
    step = 1'b0;
    clear_counts();
    repeat (60) tick();
    check_output("step_ppu_count", cnt_ppu, 12);
    check_output("step_ppu4_count", cnt_ppu4, 3);
    check_output("step_cpu_count", cnt_cpu, 1);
    check_output("step_ack_back", pause_ack, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (20) tick();
    #2;
    do_reset();
    run_to(60);
    check_output("step_reset_cpu_edge", first_cpu_edge, 56);
`endif

    $display("[TB] random pause traffic");
    do_reset();
    for (int seg = 0; seg < 40; seg++) begin
      pause_req = 1'($urandom_range(0, 1));
      dur = $urandom_range(1, 90);
      for (int k = 0; k < dur; k++) begin
`ifdef CLKEN_STEP_EN
        step = ($urandom_range(0, 7) == 0);
`endif
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Single-clock clock-enable generator on the 100 MHz PLL output. Emits one-cycle enable strobes at the PPU (21.428 MHz), PPU/4 (5.357 MHz), 6502 (1.7857 MHz) and VGA (12.5 MHz) rates, so every downstream block runs on `clk`. A pause handshake lets the debug logic freeze the emulated core on a CPU-cycle boundary while VGA keeps scanning.

## Interface
Parameters:
- `ACC_NUM`, default 3: PPU fractional-accumulator increment.
- `ACC_DEN`, default 14: PPU accumulator modulus; ce_ppu rate = clk × ACC_NUM/ACC_DEN.
- `PPU_PER_CPU`, default 12: ce_ppu strobes per ce_cpu.
- `PPU_PER_DIV4`, default 4: ce_ppu strobes per ce_ppu4.
- `VGA_DIV`, default 8: clk cycles per ce_vga.

Ports:
- `clk` in 1: 100 MHz system clock. One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous, active-low reset.
- `pause_req` in 1: level request to freeze the core at the next CPU boundary.
- `pause_ack` out 1: high while frozen.
- `step` in 1: one-cycle pulse; runs one CPU cycle while paused. Present only with `CLKEN_STEP_EN`.
- `ce_ppu` out 1: PPU enable strobe.
- `ce_ppu4` out 1: PPU/4 enable strobe.
- `ce_cpu` out 1: 6502 enable strobe.
- `ce_vga` out 1: VGA enable strobe.

## Operation
- All outputs are registered. All reset to 0: acc=0, ppu_cnt=0, div4_cnt=0, vga_cnt=0, state=RUN.
- PPU accumulator: advances on each edge unless frozen. sum = acc + ACC_NUM. If sum ≥ ACC_DEN, acc = sum − ACC_DEN and ce_ppu=1 next cycle; otherwise acc = sum.
- acc width is clog2(ACC_DEN)+1 bits, so sum never overflows.
- ppu_cnt counts ce_ppu events mod PPU_PER_CPU. ce_cpu fires together with the ce_ppu that wraps ppu_cnt to 0.
- div4_cnt works the same way mod PPU_PER_DIV4 and drives ce_ppu4.
- ce_cpu always coincides with ce_ppu and ce_ppu4.
- vga_cnt is a free-running counter mod VGA_DIV. ce_vga fires on the wrap edge. VGA is never frozen.
- State machine:
  - RUN: if pause_req is high, go to DRAIN. If the same edge also generates ce_cpu, go straight to PAUSED.
  - DRAIN: counters still run. On the edge generating ce_cpu, go to PAUSED. If pause_req drops first, go to RUN with no ack.
  - PAUSED: acc, ppu_cnt and div4_cnt are frozen. ce_ppu, ce_ppu4 and ce_cpu are held 0. pause_ack=1. When pause_req=0, go to RUN; counting resumes on the following edge from the frozen state.
  - STEP (macro only): counters run. On the edge generating ce_cpu, go back to PAUSED.
- The boundary ce_cpu that ends DRAIN or STEP is always emitted.
- Async reset mid-operation returns to reset values immediately, including while in PAUSED.

## Timing
- Edges are numbered from the first rising edge after rst_n deasserts (edge 1). Each strobe is high during the cycle after its edge.
- Default parameters: ce_ppu on edges 5, 10, 14, then period 14 (19, 24, 28, …).
- ce_ppu4 first fires on edge 19. ce_cpu first fires on edge 56, then every 56. ce_vga fires on edges 8, 16, 24, ….
- pause_ack rises one cycle after the boundary ce_cpu cycle.
- pause_ack falls one cycle after pause_req=0 is sampled.
- Worst-case pause latency: 56 clk from pause_req to pause_ack.

## Configuration
- `CLKEN_STEP_EN` defined: `step` port and STEP state exist.
  - A step pulse sampled in PAUSED enters STEP; pause_ack drops the next cycle.
  - Exactly 12 ce_ppu, 3 ce_ppu4 and 1 ce_cpu are issued, then the block returns to PAUSED.
  - step is ignored outside PAUSED, and when pause_req=0.
- Undefined: no `step` port, no STEP state.

## Structure
- Package `clk_en_pkg`:
  - state enum `clken_state_t` (RUN, DRAIN, PAUSED, STEP).
  - default constants for ACC_NUM/ACC_DEN/PPU_PER_CPU/PPU_PER_DIV4/VGA_DIV.
- Sub-module `frac_strobe`: accumulator with hold input and registered strobe, reusable for other fractional rates.

## Test plan
- Reset release, run 112 edges → ce_ppu count 24, ce_ppu4 6, ce_cpu 2 (edges 56, 112), ce_vga 14 (edge 8 first).
- pause_req asserted at edge 20 → DRAIN; ce_cpu at 56; pause_ack=1 from cycle 57; no ce_ppu through 200 while ce_vga continues.
- Release pause_req at edge 200 → pause_ack=0 next cycle; next ce_ppu is 5 active edges after resume (acc frozen at 0); ce_cpu 56 active edges later.
- pause_req asserted on edge 56 exactly → direct RUN→PAUSED; ce_cpu still emitted at 56.
- pause_req pulsed 10 cycles in DRAIN → returns to RUN, pause_ack never rises, strobe schedule unchanged.
- With `CLKEN_STEP_EN`, while paused pulse step → exactly 12 ce_ppu and 1 ce_cpu, then pause_ack re-asserts. Async rst_n low mid-STEP → all outputs 0 immediately, state RUN.
